// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide engine.
package muldiv_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_RUN,
      MD_DONE
   } muldiv_state_t;

   localparam int unsigned MD_WIDTH = 32;
   localparam int unsigned MD_CNT_W = $clog2(MD_WIDTH) + 1;

   function automatic logic op_is_signed(input muldiv_op_t op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] qreg,
   input  logic [WIDTH-1:0] breg,
   output logic [WIDTH-1:0] acc_nxt,
   output logic [WIDTH-1:0] qreg_nxt
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_sh;
   logic           ge;

   always_comb begin
      sum      = {1'b0, acc} + (qreg[0] ? {1'b0, breg} : '0);
      rem_sh   = {acc, qreg[WIDTH-1]};
      ge       = (rem_sh >= {1'b0, breg});
      acc_nxt  = '0;
      qreg_nxt = '0;
      if (is_div) begin
         // the difference is always below the divisor, so it fits in WIDTH bits
         acc_nxt  = ge ? (rem_sh[WIDTH-1:0] - breg) : rem_sh[WIDTH-1:0];
         qreg_nxt = {qreg[WIDTH-2:0], ge};
      end else begin
         acc_nxt  = sum[WIDTH:1];
         qreg_nxt = {sum[0], qreg[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine feeding the HI/LO register write port.
// Define MULDIV_FAST_MULT_EN for single-cycle multiplies.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             busy,
   output logic             done,
   output logic             hilo_we,
   output logic [WIDTH-1:0] lo_out,
   output logic [WIDTH-1:0] hi_out
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   muldiv_state_t state, state_nxt;
   muldiv_op_t    op_t;

   logic             req_signed, a_neg, b_neg, divz_req, fast_req, accept;
   logic [WIDTH-1:0] a_abs, b_abs;

   logic [WIDTH-1:0] acc, qreg, breg;
   logic [WIDTH-1:0] acc_nxt, qreg_nxt;
   logic [CNT_W-1:0] count;
   logic             is_div, neg_q, neg_r, divz;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, lo_res, hi_res;

   assign op_t = muldiv_op_t'(op);

   always_comb begin
      req_signed = op_is_signed(op_t);
      a_neg      = req_signed & srca[WIDTH-1];
      b_neg      = req_signed & srcb[WIDTH-1];
      a_abs      = a_neg ? ('0 - srca) : srca;
      b_abs      = b_neg ? ('0 - srcb) : srcb;
      divz_req   = op[1] & (srcb == '0);
`ifdef MULDIV_FAST_MULT_EN
      fast_req   = ~op[1];
`else
      fast_req   = 1'b0;
`endif
   end

`ifdef MULDIV_FAST_MULT_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_prod = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
`endif

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div   (is_div),
      .acc      (acc),
      .qreg     (qreg),
      .breg     (breg),
      .acc_nxt  (acc_nxt),
      .qreg_nxt (qreg_nxt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= MD_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         MD_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = (divz_req | fast_req) ? MD_DONE : MD_RUN;
            end
         end
         MD_RUN:  if (count == CNT_W'(WIDTH - 1)) state_nxt = MD_DONE;
         MD_DONE: state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   // magnitudes are computed unsigned; signs are restored here on the way out
   always_comb begin
      prod_fix = neg_q ? ('0 - {acc, qreg}) : {acc, qreg};
      quo_fix  = neg_q ? ('0 - qreg) : qreg;
      rem_fix  = neg_r ? ('0 - acc) : acc;
      if (divz) begin
         lo_res = '1;
         hi_res = qreg;
      end else if (is_div) begin
         lo_res = quo_fix;
         hi_res = rem_fix;
      end else begin
         lo_res = prod_fix[WIDTH-1:0];
         hi_res = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc     <= '0;
         qreg    <= '0;
         breg    <= '0;
         count   <= '0;
         is_div  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         divz    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hilo_we <= 1'b0;
         lo_out  <= '0;
         hi_out  <= '0;
      end else begin
         done    <= 1'b0;
         hilo_we <= 1'b0;
         if (accept) begin
            acc    <= '0;
            qreg   <= divz_req ? srca : a_abs;
            breg   <= b_abs;
            count  <= '0;
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            divz   <= divz_req;
            busy   <= 1'b1;
`ifdef MULDIV_FAST_MULT_EN
            if (fast_req) {acc, qreg} <= fast_prod;
`endif
         end else if (state == MD_RUN) begin
            acc   <= acc_nxt;
            qreg  <= qreg_nxt;
            count <= count + CNT_W'(1);
         end else if (state == MD_DONE) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            hilo_we <= 1'b1;
            lo_out  <= lo_res;
            hi_out  <= hi_res;
         end
      end
   end

endmodule
